// File: rtl/mod_inverse.sv
// mod_inverse: sequential modular inverter, inverse = a^-1 mod P.
// Binary extended Euclid using only shifts, compares and add/sub, so no
// multiplier is needed. One state visit per clock. P must be odd and > 2.
module mod_inverse #(
  parameter int                WIDTH = 16,
  parameter logic [WIDTH-1:0]  P     = 16'd65521
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [WIDTH-1:0] o_inverse
);

  // Explicit encoding keeps the state register easy to read in waveforms.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_HALVE_U = 3'd2,
    S_HALVE_V = 3'd3,
    S_SUB     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // x1/x2 carry one guard bit so that x+P never overflows before the shift.
  localparam logic [WIDTH:0]   PX   = {1'b0, P};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ONEX = {{WIDTH{1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_u, w_u_nxt;
  logic [WIDTH-1:0] r_v, w_v_nxt;
  logic [WIDTH:0]   r_x1, w_x1_nxt;
  logic [WIDTH:0]   r_x2, w_x2_nxt;
  logic             r_error, w_error_nxt;
  logic [WIDTH-1:0] r_inverse, w_inverse_nxt;

  // x/2 mod P: an odd x is made even by adding P (P odd) before halving.
  function automatic logic [WIDTH:0] halve_mod(input logic [WIDTH:0] x);
    logic [WIDTH:0] s;
    s = x[0] ? (x + PX) : x;
    return s >> 1;
  endfunction

  // (x - y) mod P for x, y already reduced; x+P fits in WIDTH+1 bits.
  function automatic logic [WIDTH:0] sub_mod(input logic [WIDTH:0] x,
                                             input logic [WIDTH:0] y);
    return (x >= y) ? (x - y) : (x + PX - y);
  endfunction

  // Next-state and datapath update; every target defaults to its register.
  always_comb begin
    w_state_nxt   = r_state;
    w_a_nxt       = r_a;
    w_u_nxt       = r_u;
    w_v_nxt       = r_v;
    w_x1_nxt      = r_x1;
    w_x2_nxt      = r_x2;
    w_error_nxt   = r_error;
    w_inverse_nxt = r_inverse;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt   = S_LOAD;
          w_a_nxt       = i_a;
          w_error_nxt   = 1'b0;
          w_inverse_nxt = '0;
        end
      end
      S_LOAD: begin
        if ((r_a == '0) || (r_a >= P)) begin
          // No inverse exists for 0 or an unreduced operand.
          w_state_nxt   = S_DONE;
          w_error_nxt   = 1'b1;
          w_inverse_nxt = '0;
        end else begin
          w_state_nxt = S_HALVE_U;
          w_u_nxt     = r_a;
          w_v_nxt     = P;
          w_x1_nxt    = ONEX;
          w_x2_nxt    = '0;
        end
      end
      S_HALVE_U: begin
        if ((r_u == ONE) || (r_v == ONE)) begin
          w_state_nxt   = S_DONE;
          w_inverse_nxt = (r_u == ONE) ? r_x1[WIDTH-1:0] : r_x2[WIDTH-1:0];
        end else if (!r_u[0]) begin
          w_u_nxt  = r_u >> 1;
          w_x1_nxt = halve_mod(r_x1);
        end else begin
          w_state_nxt = S_HALVE_V;
        end
      end
      S_HALVE_V: begin
        if (!r_v[0]) begin
          w_v_nxt  = r_v >> 1;
          w_x2_nxt = halve_mod(r_x2);
        end else begin
          w_state_nxt = S_SUB;
        end
      end
      S_SUB: begin
        // Both u and v are odd here, so the difference is even and the
        // next HALVE_U pass makes progress.
        if (r_u >= r_v) begin
          w_u_nxt  = r_u - r_v;
          w_x1_nxt = sub_mod(r_x1, r_x2);
        end else begin
          w_v_nxt  = r_v - r_u;
          w_x2_nxt = sub_mod(r_x2, r_x1);
        end
        w_state_nxt = S_HALVE_U;
      end
      S_DONE: begin
        // Result holds until a new request; a restart clears it.
        if (i_start) begin
          w_state_nxt   = S_LOAD;
          w_a_nxt       = i_a;
          w_error_nxt   = 1'b0;
          w_inverse_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wipes everything immediately.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_u       <= '0;
      r_v       <= '0;
      r_x1      <= '0;
      r_x2      <= '0;
      r_error   <= 1'b0;
      r_inverse <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_a       <= w_a_nxt;
      r_u       <= w_u_nxt;
      r_v       <= w_v_nxt;
      r_x1      <= w_x1_nxt;
      r_x2      <= w_x2_nxt;
      r_error   <= w_error_nxt;
      r_inverse <= w_inverse_nxt;
    end
  end

  // Status decodes straight from the state so reset clears them at once.
  assign o_busy    = (r_state == S_LOAD)    || (r_state == S_HALVE_U) ||
                     (r_state == S_HALVE_V) || (r_state == S_SUB);
  assign o_done    = (r_state == S_DONE);
  assign o_error   = r_error;
  assign o_inverse = r_inverse;

  // Coefficients must stay reduced modulo P after every update.
  a_x_reduced: assert property (@(posedge i_clk) disable iff (i_reset)
                                (r_x1 < PX) && (r_x2 < PX));

endmodule

// File: tb/tb_mod_inverse.sv
// tb_mod_inverse: randomized self-checking bench. Expected inverses come from
// Fermat's little theorem (a^(P-2) mod P) with plain integer arithmetic.
module tb_mod_inverse;
  localparam int             W       = 16;
  localparam logic [W-1:0]   P       = 16'd65521;
  localparam int             LAT_MAX = 4*W + 4;
  localparam int             TMO     = 200;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         i_start;
  logic [W-1:0] i_a;
  logic         o_busy, o_done, o_error;
  logic [W-1:0] o_inverse;

  int checks   = 0;
  int failures = 0;
  int overlap  = 0;

  always #5 i_clk = ~i_clk;

  mod_inverse #(.WIDTH(W), .P(P)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_a(i_a),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_inverse(o_inverse)
  );

  // Busy and Done must never be high together.
  always @(negedge i_clk) if (!i_reset && o_busy && o_done) overlap++;

  // Reference: a^(P-2) mod P for prime P; 0 where no inverse exists.
  function automatic longint ref_inv(input longint a);
    longint r, b, e, pp;
    pp = longint'(P);
    if (a == 0 || a >= pp) return 0;
    r = 1; b = a; e = pp - 2;
    while (e > 0) begin
      if (e % 2 == 1) r = (r * b) % pp;
      b = (b * b) % pp;
      e = e / 2;
    end
    return r;
  endfunction

  // Issue one request; lat counts edges from the accepting edge to Done.
  task automatic do_op(input logic [W-1:0] a, output int lat, output logic d0);
    @(negedge i_clk);
    i_a = a; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_a = W'($urandom);
    lat = 1; d0 = o_done;
    while (o_done !== 1'b1 && lat < TMO) begin
      @(posedge i_clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    i_reset = 1'b1; i_start = 1'b0; i_a = '0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if ({o_busy, o_done, o_error, o_inverse} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %b/%b/%b/%0d want 0/0/0/0", o_busy, o_done, o_error, o_inverse);
    end
    @(negedge i_clk); i_reset = 1'b0;
    @(posedge i_clk); #1;
    checks++;
    if ({o_busy, o_done, o_error, o_inverse} !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: got %b/%b/%b/%0d want 0/0/0/0", o_busy, o_done, o_error, o_inverse);
    end
  endtask

  task automatic test_one;
    int lat; logic d0;
    do_op(16'd1, lat, d0);
    checks++;
    if (lat !== 3) begin
      failures++; $display("FAIL one_latency: got %0d want 3", lat);
    end
    checks++;
    if (o_inverse !== 16'd1 || o_error !== 1'b0) begin
      failures++; $display("FAIL one_result: got inv=%0d err=%b want inv=1 err=0", o_inverse, o_error);
    end
  endtask

  task automatic test_boundaries;
    logic [W-1:0] tab [5];
    int lat; logic d0; logic exp_err; longint exp_inv;
    tab[0] = 16'd2; tab[1] = P - 16'd1; tab[2] = 16'd0; tab[3] = P; tab[4] = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      do_op(tab[i], lat, d0);
      exp_err = (tab[i] == 0) || (tab[i] >= P);
      exp_inv = ref_inv(longint'(tab[i]));
      checks++;
      if (o_done !== 1'b1 || (exp_err ? (lat != 2) : (lat > LAT_MAX))) begin
        failures++; $display("FAIL bound_latency a=%0d: got %0d done=%b want %s", tab[i], lat, o_done, exp_err ? "2" : "<=68");
      end
      checks++;
      if (o_error !== exp_err || longint'(o_inverse) != exp_inv) begin
        failures++; $display("FAIL bound_result a=%0d: got inv=%0d err=%b want inv=%0d err=%b", tab[i], o_inverse, o_error, exp_inv, exp_err);
      end
    end
    // Closed forms for the two named corner values.
    checks++;
    if (ref_inv(2) != (longint'(P) + 1) / 2 || ref_inv(longint'(P) - 1) != longint'(P) - 1) begin
      failures++; $display("FAIL model_closed_form: got %0d/%0d", ref_inv(2), ref_inv(longint'(P) - 1));
    end
  endtask

  task automatic test_random(input int n);
    int lat, max_lat; logic d0; logic [W-1:0] a; longint exp_inv;
    max_lat = 0;
    for (int k = 0; k < n; k++) begin
      a = W'($urandom_range(1, int'(P) - 1));
      do_op(a, lat, d0);
      exp_inv = ref_inv(longint'(a));
      if (lat > max_lat) max_lat = lat;
      checks++;
      if (o_done !== 1'b1 || o_error !== 1'b0 || longint'(o_inverse) != exp_inv) begin
        failures++; $display("FAIL random a=%0d: got inv=%0d err=%b done=%b want inv=%0d", a, o_inverse, o_error, o_done, exp_inv);
      end
      checks++;
      if ((longint'(o_inverse) * longint'(a)) % longint'(P) != 1) begin
        failures++; $display("FAIL random_product a=%0d: got inv*a mod p=%0d want 1", a, (longint'(o_inverse) * longint'(a)) % longint'(P));
      end
    end
    checks++;
    if (max_lat > LAT_MAX) begin
      failures++; $display("FAIL random_max_latency: got %0d want <=%0d", max_lat, LAT_MAX);
    end
  endtask

  task automatic test_busy_hold;
    logic [W-1:0] a0; int lat; int busy_bad;
    a0 = W'($urandom_range(2, int'(P) - 1));
    busy_bad = 0;
    @(negedge i_clk);
    i_a = a0; i_start = 1'b1;
    @(posedge i_clk); #1;
    lat = 1;
    while (o_done !== 1'b1 && lat < TMO) begin
      if (o_busy !== 1'b1) busy_bad++;
      i_a = W'($urandom);
      @(posedge i_clk); #1;
      lat++;
    end
    i_start = 1'b0;
    checks++;
    if (busy_bad != 0 || lat > LAT_MAX) begin
      failures++; $display("FAIL busy_hold_flags: got busy_low=%0d lat=%0d want 0 and <=%0d", busy_bad, lat, LAT_MAX);
    end
    checks++;
    if (longint'(o_inverse) != ref_inv(longint'(a0)) || o_error !== 1'b0) begin
      failures++; $display("FAIL busy_hold_result a=%0d: got %0d want %0d", a0, o_inverse, ref_inv(longint'(a0)));
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a1, a2; int lat; logic d0;
    a1 = W'($urandom_range(1, int'(P) - 1));
    a2 = W'($urandom_range(1, int'(P) - 1));
    do_op(a1, lat, d0);
    checks++;
    if (longint'(o_inverse) != ref_inv(longint'(a1))) begin
      failures++; $display("FAIL b2b_first a=%0d: got %0d want %0d", a1, o_inverse, ref_inv(longint'(a1)));
    end
    do_op(a2, lat, d0);
    checks++;
    if (d0 !== 1'b0) begin
      failures++; $display("FAIL b2b_done_drop: got done=%b after restart want 0", d0);
    end
    checks++;
    if (longint'(o_inverse) != ref_inv(longint'(a2)) || lat > LAT_MAX) begin
      failures++; $display("FAIL b2b_second a=%0d: got %0d lat=%0d want %0d", a2, o_inverse, lat, ref_inv(longint'(a2)));
    end
  endtask

  task automatic test_reset_mid;
    int n, lat; logic d0;
    @(negedge i_clk);
    i_a = 16'd12345; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    n = 0;
    while (int'(dut.r_state) != 4 && n < TMO) begin
      @(posedge i_clk); #1;
      n++;
    end
    #2 i_reset = 1'b1;
    #1;
    checks++;
    if (n >= TMO || {o_busy, o_done, o_error, o_inverse} !== '0 || int'(dut.r_state) != 0) begin
      failures++; $display("FAIL reset_mid: got %b/%b/%b/%0d state=%0d want all 0", o_busy, o_done, o_error, o_inverse, int'(dut.r_state));
    end
    @(negedge i_clk); i_reset = 1'b0;
    do_op(16'd3, lat, d0);
    checks++;
    if (longint'(o_inverse) != ref_inv(3) || o_error !== 1'b0 || lat > LAT_MAX) begin
      failures++; $display("FAIL after_reset_three: got %0d err=%b lat=%0d want %0d", o_inverse, o_error, lat, ref_inv(3));
    end
  endtask

  initial begin
    test_reset();
    test_one();
    test_boundaries();
    test_random(300);
    test_busy_hold();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (overlap != 0) begin
      failures++; $display("FAIL busy_done_exclusive: got %0d overlapping cycles want 0", overlap);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
